postif_id: RTL
==============

Name: postif_id

Overview:
- Consumer end of the IF→postIF fetch interface. Takes each postIF slot (PC, exception type, read-enable, valid) and pairs it with the instruction word returned by instruction memory.
- Paired entries are held in a small in-order buffer, so fetched instructions survive ID stalls. The buffer head drives the registered ID-stage inputs.
- Handles exception flush and branch wrong-path squash. Raises an early stall request back toward IF/postIF.

Parameters:
DEPTH, 4, buffer entries; power of two, ≥2
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clock_i  in  1  core clock
reset_i  in  1  asynchronous, active-low reset (`RST_ENABLE = 1'b0`)
postif_pc_i  in  32  PC of the postIF slot
postif_exception_type_i  in  32  fetch exception bits of the slot
postif_inst_ren_i  in  1  slot issued a memory read
postif_inst_valid_i  in  1  slot is live (not squashed)
inst_rdata_i  in  32  instruction word from instruction memory
inst_rdata_valid_i  in  1  inst_rdata_i belongs to the current postIF slot
branch_enable_i  in  1  branch in ID taken this cycle
exception_i  in  1  pipeline flush
id_stall_i  in  1  ID register must hold
id_pc_o  out  32  PC to ID
id_inst_o  out  32  instruction to ID
id_exception_type_o  out  32  exception bits to ID
id_valid_o  out  1  ID slot holds a real instruction
stallreq_o  out  1  buffer almost full; IF/postIF must stall

Behaviour:
- Reset (reset_i = 0, asynchronous):
  - All id_* outputs = 0.
  - count = 0; read and write pointers = 0.
  - stallreq_o = 0.
- Priority, evaluated on every posedge: reset > exception_i > branch_enable_i > normal.
- Enqueue candidate (combinational): postif_inst_valid_i && (inst_rdata_valid_i || !postif_inst_ren_i).
  - Candidate data: {postif_pc_i, inst word, postif_exception_type_i}.
  - Inst word = inst_rdata_i if postif_inst_ren_i, else 32'b0 (fetch-side exception with no read).
- Normal cycle:
  - Dequeue when !id_stall_i && count > 0. The head entry is loaded into the id_* registers and id_valid_o <= 1.
  - Bypass when !id_stall_i && count == 0 && candidate. The candidate goes straight into the id_* registers (1-cycle latency, postIF → ID) and is not written to the buffer.
  - When !id_stall_i with no head and no candidate: id_valid_o <= 0. id_pc_o, id_inst_o and id_exception_type_o hold their values.
  - When id_stall_i = 1: all id_* outputs hold.
  - A candidate that is not bypassed is written at the write pointer.
  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- stallreq_o = (count >= DEPTH-1), driven combinationally from the count register. This leaves one slot of headroom for the in-flight postIF slot.
  - An enqueue with count == DEPTH and no dequeue is a protocol violation. The entry is dropped and the bench flags it.
- exception_i = 1 (not reset):
  - count and both pointers = 0.
  - All id_* outputs = 0.
  - The candidate is discarded.
- branch_enable_i = 1 (no exception): only the delay slot survives. The delay slot is the oldest undelivered instruction: the buffer head if count > 0, otherwise the candidate.
  - If !id_stall_i: the delay slot loads into id_* with id_valid_o <= 1; count = 0; pointers reset.
  - If id_stall_i: id_* hold. The buffer is left holding only the delay slot (count = 1 at the new read pointer, write pointer = read pointer + 1). Wrong-path entries are dropped.
  - If there is no head and no candidate, nothing is dropped. Upstream squash is already applied through postif_inst_valid_i.
  - Repeated assertion while stalled is idempotent.
- No combinational path from any input to an id_* output.

Test Plan:
- Streaming: PCs 0xBFC00000, +4, +8 presented with rdata_valid each cycle and id_stall_i = 0 → id_pc_o follows one cycle later; id_valid_o = 1 continuously; count stays 0.
- Stall fill: id_stall_i = 1 for 5 cycles with DEPTH = 4 and a new candidate each cycle → stallreq_o rises when count reaches 3. After release, the 4 buffered entries emerge in order. No loss, provided upstream honours stallreq.
- Wrap: 10 enqueue/dequeue pairs at count = 2 → PC order preserved across pointer wrap.
- Fetch exception: postif_inst_ren_i = 0, exception_type = 0x4 (AdEL), pc = 0x1 → id_inst_o = 0, id_exception_type_o = 0x4, id_valid_o = 1.
- Branch: buffer holds pcs 0x100, 0x104, 0x108 and branch_enable_i pulses with id_stall_i = 0 → id_pc_o = 0x100, count = 0. Repeat with id_stall_i = 1 → count = 1, and 0x100 is delivered after release.
- Exception flush and async reset: exception_i with count = 3 → next cycle id_valid_o = 0 and count = 0. Dropping reset_i mid-cycle → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/postif_id.sv
// postif_id: pairs each postIF fetch slot with its instruction-memory word,
// buffers the pairs in order so nothing is lost while ID is stalled, and
// presents the oldest one through registered ID-stage outputs.
module postif_id #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] postif_pc_i,
  input  logic [31:0] postif_exception_type_i,
  input  logic        postif_inst_ren_i,
  input  logic        postif_inst_valid_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        inst_rdata_valid_i,
  input  logic        branch_enable_i,
  input  logic        exception_i,
  input  logic        id_stall_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_exception_type_o,
  output logic        id_valid_o,
  output logic        stallreq_o
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic             RST_ENABLE = 1'b0;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

  logic [31:0] buf_pc   [DEPTH];
  logic [31:0] buf_inst [DEPTH];
  logic [31:0] buf_exc  [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0] count, count_n;

  logic        cand;
  logic [31:0] cand_inst;
  logic        has_head;
  logic        full;
  logic        deq;
  logic        byp;
  logic        enq;
  logic        wr_en;
  logic        id_load;
  logic        id_sel_head;
  logic        id_drop_valid;
  logic        id_clear;

  // A slot is ready to enqueue once its word has arrived, or at once when it
  // never issued a read (fetch-side exception carries a zero instruction).
  always_comb begin
    cand      = postif_inst_valid_i && (inst_rdata_valid_i || !postif_inst_ren_i);
    cand_inst = postif_inst_ren_i ? inst_rdata_i : 32'b0;
    has_head  = (count != '0);
    full      = (count == FULL_CNT);
  end

  // Buffer/ID control: flush beats branch squash beats normal flow.
  always_comb begin
    count_n       = count;
    rd_ptr_n      = rd_ptr;
    wr_ptr_n      = wr_ptr;
    wr_en         = 1'b0;
    id_load       = 1'b0;
    id_sel_head   = 1'b0;
    id_drop_valid = 1'b0;
    id_clear      = 1'b0;
    deq           = 1'b0;
    byp           = 1'b0;
    enq           = 1'b0;
    if (exception_i) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      id_clear = 1'b1;
    end else if (branch_enable_i) begin
      // Only the delay slot (oldest undelivered instruction) survives.
      if (!id_stall_i) begin
        id_load       = has_head || cand;
        id_sel_head   = has_head;
        id_drop_valid = !(has_head || cand);
        count_n       = '0;
        rd_ptr_n      = '0;
        wr_ptr_n      = '0;
      end else if (has_head) begin
        count_n  = ONE_CNT;
        wr_ptr_n = rd_ptr + ONE_PTR;
      end else if (cand) begin
        // Empty buffer: wr_ptr equals rd_ptr, so the slot lands at the head.
        wr_en    = 1'b1;
        count_n  = ONE_CNT;
        wr_ptr_n = rd_ptr + ONE_PTR;
      end
    end else begin
      deq           = !id_stall_i && has_head;
      byp           = !id_stall_i && !has_head && cand;
      enq           = cand && !byp && (!full || deq);
      id_load       = deq || byp;
      id_sel_head   = deq;
      id_drop_valid = !id_stall_i && !has_head && !cand;
      wr_en         = enq;
      if (enq) wr_ptr_n = wr_ptr + ONE_PTR;
      if (deq) rd_ptr_n = rd_ptr + ONE_PTR;
      case ({enq, deq})
        2'b10:   count_n = count + ONE_CNT;
        2'b01:   count_n = count - ONE_CNT;
        default: count_n = count;
      endcase
    end
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (reset_i == RST_ENABLE) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      buf_pc[wr_ptr]   <= postif_pc_i;
      buf_inst[wr_ptr] <= cand_inst;
      buf_exc[wr_ptr]  <= postif_exception_type_i;
    end
  end

  // ID-stage registers, loaded from the buffer head or straight from postIF.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (reset_i == RST_ENABLE) begin
      id_pc_o             <= 32'b0;
      id_inst_o           <= 32'b0;
      id_exception_type_o <= 32'b0;
      id_valid_o          <= 1'b0;
    end else if (id_clear) begin
      id_pc_o             <= 32'b0;
      id_inst_o           <= 32'b0;
      id_exception_type_o <= 32'b0;
      id_valid_o          <= 1'b0;
    end else if (id_load) begin
      id_pc_o             <= id_sel_head ? buf_pc[rd_ptr]   : postif_pc_i;
      id_inst_o           <= id_sel_head ? buf_inst[rd_ptr] : cand_inst;
      id_exception_type_o <= id_sel_head ? buf_exc[rd_ptr]  : postif_exception_type_i;
      id_valid_o          <= 1'b1;
    end else if (id_drop_valid) begin
      id_valid_o <= 1'b0;
    end
  end

  // One free slot is kept for the postIF slot already in flight.
  assign stallreq_o = (count >= STALL_CNT);

endmodule
